// File: rtl/apb_req_arbiter.sv
// Shares one APB_Master internal interface between NUM_REQ requesters: arbitrates, sequences, routes completion.
// Define APB_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); round-robin otherwise.
module apb_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         req_rdata,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic                      transfer,
  output logic                      write,
  output logic [ADDR_W-1:0]         addr,
  output logic [DATA_W-1:0]         wdata,
  input  logic                      ready,
  input  logic [DATA_W-1:0]         rdata,
  output logic [1:0]                state_dbg
);

  // Handshakes: a requester raises req with its payload and holds it until the
  // single-cycle req_ready pulse; toward the master, transfer is a one-cycle start
  // pulse and ready (seen in XFER or WAIT) marks completion with rdata valid.

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t           state;
  logic             found;
  logic [IDX_W-1:0] win;
  logic [IDX_W-1:0] cand;
  logic             active;

`ifndef APB_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W:0]   sum;
`endif

  // First requesting index scanning from the search start, wrapping at NUM_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
`ifndef APB_ARB_FIXED_PRIO_EN
    sum   = '0;
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
`ifdef APB_ARB_FIXED_PRIO_EN
      cand = IDX_W'(i);
`else
      sum = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      cand = sum[IDX_W-1:0];
`endif
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign active    = (state == S_XFER) || (state == S_WAIT);
  assign busy      = (state != S_IDLE);
  assign req_ready = (active && ready) ? grant : '0;
  assign req_rdata = (active && ready) ? rdata : '0;
  assign state_dbg = state;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state    <= S_IDLE;
      grant    <= '0;
      transfer <= 1'b0;
      write    <= 1'b0;
      addr     <= '0;
      wdata    <= '0;
`ifndef APB_ARB_FIXED_PRIO_EN
      rr_ptr   <= '0;
      win_idx  <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            state    <= S_XFER;
            grant    <= NUM_REQ'(1) << win;
            write    <= req_write[win];
            addr     <= req_addr[int'(win)*ADDR_W +: ADDR_W];
            wdata    <= req_wdata[int'(win)*DATA_W +: DATA_W];
            transfer <= 1'b1;
`ifndef APB_ARB_FIXED_PRIO_EN
            win_idx  <= win;
`endif
          end
        end
        S_XFER, S_WAIT: begin
          transfer <= 1'b0;
          if (ready) begin
            state <= S_IDLE;
            grant <= '0;
`ifndef APB_ARB_FIXED_PRIO_EN
            rr_ptr <= (win_idx == IDX_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
`endif
          end else begin
            state <= S_WAIT;
          end
        end
        default: begin
          state    <= S_IDLE;
          grant    <= '0;
          transfer <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: a behavioural APB_Master/slave responder and scripted requesters.
// Expected completions are queued at issue time and popped when req_ready pulses.
module tb_apb_req_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int W  = 68;  // {write, idx[2:0], addr[31:0], data[31:0]}
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  logic            PCLK = 1'b0;
  logic            PRESET;
  logic [N-1:0]    req;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   req_rdata;
  logic [N-1:0]    grant;
  logic            busy;
  logic            transfer;
  logic            write;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata;
  logic            ready;
  logic [DW-1:0]   rdata;
  logic [1:0]      state_dbg;

  apb_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req(req), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .req_rdata(req_rdata), .grant(grant), .busy(busy),
    .transfer(transfer), .write(write), .addr(addr), .wdata(wdata),
    .ready(ready), .rdata(rdata), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  int remaining[N];
  logic stall = 1'b0;
  logic prev_transfer = 1'b0;
  logic [31:0] mem[16];
  logic        m_write;
  logic [31:0] m_addr, m_wdata;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge PCLK);
    PRESET = 1'b1;
    req = '0;
    for (int i = 0; i < N; i++) remaining[i] = 0;
    @(negedge PCLK);
    PRESET = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic expect_txn(input int idx, input logic wr, input logic [31:0] a, input logic [31:0] d);
    logic [2:0] i3;
    i3 = 3'(idx);
    exp_q.push_back({wr, i3, a, d});
  endtask

  task automatic issue(input int idx, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input int count);
    req_write[idx]          = wr;
    req_addr[idx*AW +: AW]  = a;
    req_wdata[idx*DW +: DW] = d;
    remaining[idx]          = count;
    req[idx]                = 1'b1;
  endtask

  task automatic wait_done();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge PCLK);
      if (exp_q.size() == 0 && !busy && req == '0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      check("timeout_wait_done", 64'd1, 64'd0);
      exp_q.delete();
      req = '0;
    end
  endtask

  // Behavioural master + slaves: random completion latency, junk on rdata when idle.
  initial begin
    ready = 1'b0;
    rdata = JUNK;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    forever begin
      @(posedge PCLK); #1;
      if (transfer) begin
        int dly;
        m_write = write;
        m_addr  = addr;
        m_wdata = wdata;
        dly = $urandom_range(0, 3);
        for (int k = 0; k < dly; k++) begin @(posedge PCLK); #1; end
        while (stall) begin @(posedge PCLK); #1; end
        ready = 1'b1;
        rdata = m_write ? 32'h0 : mem[m_addr[15:12]];
        if (m_write) mem[m_addr[15:12]] = m_wdata;
        @(posedge PCLK); #1;
        ready = 1'b0;
        rdata = JUNK;
      end
    end
  end

  // ---------------- scoreboard / requester release ----------------
  initial begin
    logic [W-1:0] e;
    logic [3:0]   oh;
    forever begin
      @(negedge PCLK);
      if (!PRESET) begin
        if (transfer) check("xfer_one_cycle", 64'(prev_transfer), 64'd0);
        prev_transfer = transfer;
        if (req_ready != '0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_req_ready", 64'(req_ready), 64'd0);
          end else begin
            e  = exp_q.pop_front();
            oh = 4'(1) << e[66:64];
            check("req_ready_onehot", 64'(req_ready), 64'(oh));
            check("grant_at_ready", 64'(grant), 64'(oh));
            check("master_write", 64'(m_write), 64'(e[67]));
            check("master_addr", 64'(m_addr), 64'(e[63:32]));
            if (e[67]) check("master_wdata", 64'(m_wdata), 64'(e[31:0]));
            else       check("req_rdata", 64'(req_rdata), 64'(e[31:0]));
          end
          for (int i = 0; i < N; i++) begin
            if (req_ready[i]) begin
              if (remaining[i] > 0) remaining[i]--;
              if (remaining[i] == 0) req[i] = 1'b0;
            end
          end
        end else begin
          check("req_rdata_zero", 64'(req_rdata), 64'd0);
        end
      end else begin
        prev_transfer = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- tests ----------------
  initial begin
    int lat;
    bit seen;
    PRESET    = 1'b1;
    req       = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < N; i++) remaining[i] = 0;
    @(negedge PCLK); #1;
    check("rst_transfer", 64'(transfer), 64'd0);
    check("rst_write", 64'(write), 64'd0);
    check("rst_addr", 64'(addr), 64'd0);
    check("rst_wdata", 64'(wdata), 64'd0);
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_req_rdata", 64'(req_rdata), 64'd0);
    @(negedge PCLK);
    PRESET = 1'b0;

    // 1: single write
    @(negedge PCLK);
    expect_txn(0, 1'b1, 32'h1000_0000, 32'd10);
    issue(0, 1'b1, 32'h1000_0000, 32'd10, 1);
    seen = 1'b0;
    lat  = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge PCLK);
      if (transfer) begin seen = 1'b1; lat = c; break; end
    end
    check("t1_transfer_seen", 64'(seen), 64'd1);
    check("t1_latency", 64'(lat), 64'd0);
    check("t1_write", 64'(write), 64'd1);
    check("t1_addr", 64'(addr), 64'h1000_0000);
    check("t1_wdata", 64'(wdata), 64'd10);
    check("t1_grant", 64'(grant), 64'b0001);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_state_xfer", 64'(state_dbg), 64'd1);
    @(negedge PCLK);
    check("t1_transfer_drop", 64'(transfer), 64'd0);
    wait_done();
    check("t1_busy_after", 64'(busy), 64'd0);

    // 2: simultaneous writes from a fresh pointer
    apply_reset();
    @(negedge PCLK);
    expect_txn(0, 1'b1, 32'h1000_0000, 32'd10);
    expect_txn(1, 1'b1, 32'h1000_1000, 32'd11);
    expect_txn(2, 1'b1, 32'h1000_2000, 32'd12);
    issue(0, 1'b1, 32'h1000_0000, 32'd10, 1);
    issue(1, 1'b1, 32'h1000_1000, 32'd11, 1);
    issue(2, 1'b1, 32'h1000_2000, 32'd12, 1);
    wait_done();

    // 3: two requesters held for two transactions each
    @(negedge PCLK);
`ifdef APB_ARB_FIXED_PRIO_EN
    expect_txn(0, 1'b1, 32'h1000_4000, 32'd20);
    expect_txn(0, 1'b1, 32'h1000_4000, 32'd20);
    expect_txn(1, 1'b1, 32'h1000_5000, 32'd21);
    expect_txn(1, 1'b1, 32'h1000_5000, 32'd21);
`else
    expect_txn(0, 1'b1, 32'h1000_4000, 32'd20);
    expect_txn(1, 1'b1, 32'h1000_5000, 32'd21);
    expect_txn(0, 1'b1, 32'h1000_4000, 32'd20);
    expect_txn(1, 1'b1, 32'h1000_5000, 32'd21);
`endif
    issue(0, 1'b1, 32'h1000_4000, 32'd20, 2);
    issue(1, 1'b1, 32'h1000_5000, 32'd21, 2);
    wait_done();

    // 4: read-backs
    @(negedge PCLK);
    expect_txn(3, 1'b0, 32'h1000_1000, 32'd11);
    issue(3, 1'b0, 32'h1000_1000, 32'd0, 1);
    wait_done();
    expect_txn(3, 1'b0, 32'h1000_0000, 32'd10);
    issue(3, 1'b0, 32'h1000_0000, 32'd0, 1);
    wait_done();
    expect_txn(0, 1'b0, 32'h1000_2000, 32'd12);
    issue(0, 1'b0, 32'h1000_2000, 32'd0, 1);
    wait_done();

    // 5: reset while waiting; stalled completion then lands while idle
    stall = 1'b1;
    @(negedge PCLK);
    issue(2, 1'b0, 32'h1000_1000, 32'd0, 1);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge PCLK);
      if (state_dbg == 2'd2) begin seen = 1'b1; break; end
    end
    check("t5_reached_wait", 64'(seen), 64'd1);
    check("t5_busy_before", 64'(busy), 64'd1);
    PRESET = 1'b1;
    #1;
    check("t5_transfer_async", 64'(transfer), 64'd0);
    check("t5_grant_async", 64'(grant), 64'd0);
    check("t5_busy_async", 64'(busy), 64'd0);
    check("t5_state_async", 64'(state_dbg), 64'd0);
    check("t5_req_ready_async", 64'(req_ready), 64'd0);
    req = '0;
    for (int i = 0; i < N; i++) remaining[i] = 0;
    @(negedge PCLK);
    PRESET = 1'b0;
    stall  = 1'b0;
    repeat (6) @(negedge PCLK);
    check("t5_idle_after_stray_ready", 64'(busy), 64'd0);
    expect_txn(1, 1'b1, 32'h1000_6000, 32'd33);
    issue(1, 1'b1, 32'h1000_6000, 32'd33, 1);
    wait_done();

    // 6: requesters 0 and 2 held together
    @(negedge PCLK);
`ifdef APB_ARB_FIXED_PRIO_EN
    expect_txn(0, 1'b1, 32'h1000_7000, 32'd40);
    expect_txn(0, 1'b1, 32'h1000_7000, 32'd40);
    expect_txn(0, 1'b1, 32'h1000_7000, 32'd40);
    expect_txn(2, 1'b1, 32'h1000_8000, 32'd42);
    issue(0, 1'b1, 32'h1000_7000, 32'd40, 3);
    issue(2, 1'b1, 32'h1000_8000, 32'd42, 1);
`else
    expect_txn(2, 1'b1, 32'h1000_8000, 32'd42);
    expect_txn(0, 1'b1, 32'h1000_7000, 32'd40);
    expect_txn(2, 1'b1, 32'h1000_8000, 32'd42);
    expect_txn(0, 1'b1, 32'h1000_7000, 32'd40);
    issue(0, 1'b1, 32'h1000_7000, 32'd40, 2);
    issue(2, 1'b1, 32'h1000_8000, 32'd42, 2);
`endif
    wait_done();
    check("final_busy", 64'(busy), 64'd0);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
